// File: rtl/usb_pkg.sv
// Shared USB definitions: TX CRC-append FSM states and USB CRC16 constants.
package usb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC1 = 2'd2,
        CRC2 = 2'd3
    } crc_append_state_t;

    // Reflected form of x^16 + x^15 + x^2 + 1 (0x8005), bytes processed LSB first.
    localparam logic [15:0] USB_CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] USB_CRC16_INIT      = 16'hFFFF;
    // Good-packet residual in polynomial (MSB-first) bit order.
    localparam logic [15:0] USB_CRC16_RESIDUAL  = 16'h800D;

endpackage

// File: rtl/usb_crc16_byte.sv
// One-byte USB CRC16 update, purely combinational; shared by TX append and RX check.
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] w_c;

    // Eight LSB-first shift/XOR steps of the reflected polynomial.
    always_comb begin
        w_c = crc_in ^ {8'h00, data};
        for (int unsigned i = 0; i < 8; i++) begin
            w_c = w_c[0] ? ((w_c >> 1) ^ USB_CRC16_POLY_REFL) : (w_c >> 1);
        end
        crc_out = w_c;
    end

endmodule

// File: rtl/usb_crc16_append.sv
// USB TX stage: forwards DATA payload bytes and appends CRC16 (low byte, then high byte).
module usb_crc16_append
    import usb_pkg::*;
#(
    parameter logic [15:0] CRC_INIT   = USB_CRC16_INIT,
    parameter logic [15:0] CRC_XOROUT = 16'hFFFF,
    parameter int          MAX_BYTES  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [10:0] pkt_len,
    output logic        len_err
);

    crc_append_state_t r_state, w_state_nxt;
    logic [15:0] r_crc, w_crc_nxt;
    logic [10:0] r_count, w_count_nxt;
    logic [7:0]  r_out_data, w_out_data_nxt;
    logic        r_out_valid, w_out_valid_nxt;
    logic        r_out_last, w_out_last_nxt;
    logic [10:0] r_pkt_len, w_pkt_len_nxt;
    logic        r_len_err, w_len_err_nxt;

    logic        w_slot_free;
    logic        w_in_fire;
    logic [15:0] w_crc_src;
    logic [15:0] w_crc_upd;
    logic [15:0] w_crc_tx;

    // The first byte of a packet always starts from CRC_INIT, whatever r_crc holds.
    assign w_crc_src = (r_state == IDLE) ? CRC_INIT : r_crc;
    assign w_crc_tx  = r_crc ^ CRC_XOROUT;

    usb_crc16_byte u_crc16_byte (
        .crc_in  (w_crc_src),
        .data    (in_data),
        .crc_out (w_crc_upd)
    );

    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = ((r_state == IDLE) || (r_state == DATA)) && w_slot_free;
    assign w_in_fire   = in_valid && in_ready;

    // Next-state and next-output-register logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_crc_nxt       = r_crc;
        w_count_nxt     = r_count;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid && !out_ready;
        w_out_last_nxt  = r_out_last;
        w_pkt_len_nxt   = r_pkt_len;
        w_len_err_nxt   = 1'b0;

        unique case (r_state)
            IDLE, DATA: begin
                if (w_in_fire) begin
                    w_out_data_nxt  = in_data;
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = 1'b0;
                    w_crc_nxt       = w_crc_upd;
                    if (r_state == IDLE) begin
                        w_count_nxt = 11'd1;
                    end else begin
                        w_count_nxt   = (r_count == 11'h7FF) ? r_count : r_count + 11'd1;
                        w_len_err_nxt = (r_count == 11'(MAX_BYTES));
                    end
                    w_state_nxt = in_last ? CRC1 : DATA;
                end
            end
            CRC1: begin
                if (w_slot_free) begin
                    w_out_data_nxt  = w_crc_tx[7:0];
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = 1'b0;
                    w_state_nxt     = CRC2;
                end
            end
            CRC2: begin
                if (w_slot_free) begin
                    w_out_data_nxt  = w_crc_tx[15:8];
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = 1'b1;
                    w_pkt_len_nxt   = r_count;
                    w_crc_nxt       = CRC_INIT;
                    w_state_nxt     = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_crc       <= CRC_INIT;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_pkt_len   <= '0;
            r_len_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_crc       <= w_crc_nxt;
            r_count     <= w_count_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_pkt_len   <= w_pkt_len_nxt;
            r_len_err   <= w_len_err_nxt;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign pkt_len   = r_pkt_len;
    assign len_err   = r_len_err;

endmodule
